embedded_pio_capture: RTL and testbench

EMBEDDED_PIO_CAPTURE -- requirements
Module: embedded_pio_capture

---
 rtl/embedded_pio_pkg.sv | 14 +
 rtl/embedded_pio_sync.sv | 34 +++
 rtl/embedded_pio_capture.sv | 103 ++++++++++
 tb/tb_embedded_pio_capture.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/embedded_pio_pkg.sv
// Shared register map and edge-type encodings for the PIO capture block.
// Imported by the top and the synchronizer so both agree on constants.
package embedded_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/embedded_pio_sync.sv
// Multi-flop synchronizer for asynchronous inputs; output lags input by STAGES clocks.
// pre_o is the stage that becomes sync_o on the next clock, used to seed edge history.
module embedded_pio_sync
    import embedded_pio_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] pre_o
);

    logic [WIDTH-1:0] chain_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign pre_o  = chain_q[STAGES-2];

endmodule

// File: rtl/embedded_pio_capture.sv
// Avalon-MM PIO input port with synchronizer, edge capture and masked level interrupt.
// Read data is registered (1-cycle latency, no wait states); edges land in EDGECAP SYNC_STAGES+1 clocks after input change.
module embedded_pio_capture
    import embedded_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    // A 4-deep chain needs the count to reach 4, which does not fit in two bits.
    localparam int              ARM_W   = (SYNC_STAGES > 3) ? 3 : 2;
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES);

    logic [DATA_WIDTH-1:0] sync_w;
    logic [DATA_WIDTH-1:0] pre_w;
    logic [DATA_WIDTH-1:0] prev_q,     prev_d;
    logic [DATA_WIDTH-1:0] irqmask_q,  irqmask_d;
    logic [DATA_WIDTH-1:0] edgecap_q,  edgecap_d;
    logic [DATA_WIDTH-1:0] edge_w;
    logic [DATA_WIDTH-1:0] clr_w;
    logic [DATA_WIDTH-1:0] wdata_w;
    logic [ARM_W-1:0]      arm_q,      arm_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  armed_w;
    logic                  wr_w;
    logic                  unused_wdata;

    embedded_pio_sync #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (reset_n),
        .async_i (in_port),
        .sync_o  (sync_w),
        .pre_o   (pre_w)
    );

    assign unused_wdata = ^writedata;

    always_comb begin
        wr_w    = chipselect & ~write_n;
        wdata_w = writedata[DATA_WIDTH-1:0];
        armed_w = (arm_q == ARM_MAX);
        arm_d   = armed_w ? arm_q : arm_q + ARM_W'(1);

        // While arming, prev tracks the value sync is about to take so the
        // chain filling up after reset never looks like an edge.
        prev_d  = armed_w ? sync_w : pre_w;

        case (EDGE_TYPE)
            EDGE_FALL: edge_w = ~sync_w & prev_q;
            EDGE_ANY:  edge_w = sync_w ^ prev_q;
            default:   edge_w = sync_w & ~prev_q;
        endcase
        if (!armed_w) begin
            edge_w = '0;
        end

        clr_w     = (wr_w && address == ADDR_EDGECAP) ? wdata_w : '0;
        edgecap_d = (edgecap_q & ~clr_w) | edge_w;
        irqmask_d = (wr_w && address == ADDR_IRQMASK) ? wdata_w : irqmask_q;

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[DATA_WIDTH-1:0] = sync_w;
            ADDR_IRQMASK: readdata_d[DATA_WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[DATA_WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            arm_q      <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= prev_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            arm_q      <= arm_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_embedded_pio_capture.sv
// Scoreboard bench: reads push expected readdata/irq, a negedge monitor pops and compares.
// Instance A: 16-bit rising-edge; instance B: 8-bit any-edge; both share the bus.
module tb_embedded_pio_capture;
    import embedded_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;
    logic [15:0] in_a;
    logic [7:0]  in_b;

    typedef struct packed {
        logic        sel;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;
    bit    issue   = 1'b0;
    bit    rd_pend = 1'b0;
    int    n_chk   = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    embedded_pio_capture #(
        .DATA_WIDTH (16),
        .EDGE_TYPE  (EDGE_RISE),
        .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_a), .irq(irq_a)
    );

    embedded_pio_capture #(
        .DATA_WIDTH (8),
        .EDGE_TYPE  (EDGE_ANY),
        .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .in_port(in_b), .irq(irq_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= issue;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_read: got a read with no expectation queued");
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                check({mon_n, "_rd"},  mon_e.sel ? rd_b : rd_a, mon_e.rd);
                check({mon_n, "_irq"}, {31'b0, mon_e.sel ? irq_b : irq_a}, {31'b0, mon_e.irq});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic sel, input logic [1:0] a, input logic [31:0] erd,
                      input logic eirq, input string nm);
        address = a;
        issue   = 1'b1;
        exp_q.push_back('{sel: sel, rd: erd, irq: eirq});
        name_q.push_back(nm);
        tick();
        issue = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_a       = 16'hA5A5;
        in_b       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_a",  rd_a, 32'h0);
        check("rst_irq_a", {31'b0, irq_a}, 32'h0);
        check("rst_rd_b",  rd_b, 32'h0);

        // Inputs held high through reset: data appears, no spurious capture.
        reset_n = 1'b1;
        wait_n(2);
        rd(1'b0, ADDR_DATA,    32'h0000A5A5, 1'b0, "data_a");
        rd(1'b0, ADDR_EDGECAP, 32'h0,        1'b0, "arm_ec_a");
        rd(1'b1, ADDR_EDGECAP, 32'h0,        1'b0, "arm_ec_b");

        bus_write(ADDR_IRQMASK, 32'h0000_0001, 1'b1);
        rd(1'b0, ADDR_IRQMASK, 32'h1, 1'b0, "mask_a");

        // Falling edge on a rising-edge port is ignored.
        in_a = 16'hA5A4;
        wait_n(4);
        rd(1'b0, ADDR_EDGECAP, 32'h0, 1'b0, "fall_ignored");

        // Rising bit0: captured exactly three clocks after the input change.
        in_a = 16'hA5A5;
        tick();
        rd(1'b0, ADDR_EDGECAP, 32'h0, 1'b0, "lat_c2");
        rd(1'b0, ADDR_EDGECAP, 32'h0, 1'b1, "lat_c3");
        rd(1'b0, ADDR_EDGECAP, 32'h1, 1'b1, "lat_c4");

        in_a = 16'hA5A7;
        wait_n(4);
        rd(1'b0, ADDR_EDGECAP, 32'h3, 1'b1, "ec_two_bits");
        bus_write(ADDR_EDGECAP, 32'h0000_0001, 1'b1);
        check("irq_drop", {31'b0, irq_a}, 32'h0);
        rd(1'b0, ADDR_EDGECAP, 32'h2, 1'b0, "w1c_bit0");

        in_a = 16'hA5A6;
        wait_n(4);
        rd(1'b0, ADDR_EDGECAP, 32'h2, 1'b0, "fall_no_new");

        // Mask changes affect irq next clock without touching EDGECAP.
        bus_write(ADDR_IRQMASK, 32'h0000_0002, 1'b1);
        check("irq_unmask", {31'b0, irq_a}, 32'h1);
        rd(1'b0, ADDR_EDGECAP, 32'h2, 1'b1, "unmask_ec");
        bus_write(ADDR_IRQMASK, 32'h0000_0000, 1'b1);
        check("irq_mask0", {31'b0, irq_a}, 32'h0);
        rd(1'b0, ADDR_EDGECAP, 32'h2, 1'b0, "mask_keeps_ec");
        bus_write(ADDR_IRQMASK, 32'h0000_0001, 1'b1);

        // Edge on bit0 lands on the same clock as a clear of bit0: set wins.
        in_a = 16'hA5A7;
        wait_n(2);
        bus_write(ADDR_EDGECAP, 32'h0000_0001, 1'b1);
        rd(1'b0, ADDR_EDGECAP, 32'h3, 1'b1, "set_wins");
        bus_write(ADDR_EDGECAP, 32'h0000_0001, 1'b1);
        rd(1'b0, ADDR_EDGECAP, 32'h2, 1'b0, "clr_after");

        // Narrow any-edge port: widths, reserved word, chipselect qualification.
        bus_write(ADDR_IRQMASK, 32'hFFFF_FFFF, 1'b1);
        rd(1'b1, ADDR_IRQMASK, 32'h0000_00FF, 1'b0, "mask_b_w8");
        rd(1'b0, ADDR_IRQMASK, 32'h0000_FFFF, 1'b1, "mask_a_w16");
        bus_write(ADDR_IRQMASK, 32'h0000_0000, 1'b0);
        rd(1'b1, ADDR_IRQMASK, 32'h0000_00FF, 1'b0, "no_cs_ignored");

        in_b = 8'h80;
        wait_n(4);
        rd(1'b1, ADDR_EDGECAP, 32'h80, 1'b1, "any_rise7");
        bus_write(ADDR_EDGECAP, 32'h0000_0080, 1'b1);
        rd(1'b1, ADDR_EDGECAP, 32'h00, 1'b0, "any_clr7");
        in_b = 8'h00;
        wait_n(4);
        rd(1'b1, ADDR_EDGECAP, 32'h80, 1'b1, "any_fall7");
        rd(1'b1, ADDR_RSVD,    32'h0,  1'b1, "rsvd_b");
        bus_write(ADDR_RSVD, 32'hFFFF_FFFF, 1'b1);
        rd(1'b1, ADDR_RSVD,    32'h0,  1'b1, "rsvd_after_wr");
        rd(1'b1, ADDR_DATA,    32'h0,  1'b1, "data_b_zero");

        in_b = 8'hFF;
        wait_n(4);
        rd(1'b1, ADDR_EDGECAP, 32'hFF, 1'b1, "ec_b_full");
        rd(1'b1, ADDR_DATA,    32'hFF, 1'b1, "data_b_full");
        drain();

        // Asynchronous reset clears outputs before the next clock edge.
        reset_n = 1'b0;
        #1;
        check("arst_rd_b",  rd_b, 32'h0);
        check("arst_irq_b", {31'b0, irq_b}, 32'h0);
        check("arst_rd_a",  rd_a, 32'h0);
        check("arst_irq_a", {31'b0, irq_a}, 32'h0);
        wait_n(2);
        reset_n = 1'b1;
        wait_n(4);
        rd(1'b1, ADDR_EDGECAP, 32'h0,  1'b0, "rearm_ec_b");
        rd(1'b1, ADDR_IRQMASK, 32'h0,  1'b0, "rearm_mask_b");
        rd(1'b1, ADDR_DATA,    32'hFF, 1'b0, "rearm_data_b");
        rd(1'b0, ADDR_EDGECAP, 32'h0,  1'b0, "rearm_ec_a");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
